dm_responder: RTL and testbench

//   Data-memory responder on the M-stage store/load interface. Accepts byte

---
 rtl/dm_responder.sv | 118 +++++++++++
 tb/tb_dm_responder.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_responder.sv
// Data-memory responder for the M-stage load/store port: masked word writes,
// extended lane-selected loads, and a post-reset clearing sweep that stalls the pipe.
module dm_responder #(
  parameter int DEPTH  = 3072,
  parameter int ADDR_W = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m_data_addr,
  input  logic [3:0]  m_data_byteen,
  input  logic [31:0] m_data_wdata,
  input  logic [2:0]  dm_op,
  output logic [31:0] m_data_rdata,
  output logic        busy,
  output logic        addr_err,
  output logic [31:0] wr_count
);

  typedef enum logic {
    INIT,
    READY
  } state_t;

  localparam logic [31:0] LIMIT    = 32'(4 * DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  state_t            state;
  state_t            next_state;
  logic [ADDR_W-1:0] sweep_idx;
  logic [ADDR_W-1:0] idx;
  logic              in_range;
  logic              wr_en;
  logic              err_set;
  logic [31:0]       word;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;

  logic [31:0] mem [DEPTH];

  assign idx      = m_data_addr[ADDR_W+1:2];
  assign in_range = (m_data_addr < LIMIT);
  assign busy     = (state == INIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= INIT;
      sweep_idx <= '0;
      addr_err  <= 1'b0;
      wr_count  <= '0;
    end else begin
      state <= next_state;
      if (state == INIT) begin
        sweep_idx <= sweep_idx + 1'b1;
      end
      if (err_set) begin
        addr_err <= 1'b1;
      end
      if (wr_en && (wr_count != 32'hFFFF_FFFF)) begin
        wr_count <= wr_count + 32'd1;
      end
    end
  end

  always_comb begin
    next_state = state;
    wr_en      = 1'b0;
    err_set    = 1'b0;
    case (state)
      INIT: begin
        if (sweep_idx == LAST_IDX) begin
          next_state = READY;
        end
      end
      READY: begin
        wr_en   = (m_data_byteen != 4'b0000) && in_range;
        err_set = (m_data_byteen != 4'b0000) && !in_range;
      end
      default: next_state = INIT;
    endcase
  end

  // Array has no reset of its own; the sweep is what clears it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == INIT) begin
        mem[sweep_idx] <= '0;
      end else if (wr_en) begin
        for (int i = 0; i < 4; i++) begin
          if (m_data_byteen[i]) begin
            mem[idx][8*i +: 8] <= m_data_wdata[8*i +: 8];
          end
        end
      end
    end
  end

  always_comb begin
    word = '0;
    if ((state == READY) && in_range) begin
      word = mem[idx];
    end
    case (m_data_addr[1:0])
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = m_data_addr[1] ? word[31:16] : word[15:0];
    case (dm_op)
      3'd1:    m_data_rdata = {24'h0, byte_sel};
      3'd2:    m_data_rdata = {{24{byte_sel[7]}}, byte_sel};
      3'd3:    m_data_rdata = {16'h0, half_sel};
      3'd4:    m_data_rdata = {{16{half_sel[15]}}, half_sel};
      default: m_data_rdata = word;
    endcase
  end

endmodule

// File: tb/tb_dm_responder.sv
// Directed self-checking bench for dm_responder at DEPTH=16: reset sweep,
// masked stores, load extension, out-of-range stores and reset recovery.
module tb_dm_responder;

  logic        clk;
  logic        reset;
  logic [31:0] m_data_addr;
  logic [3:0]  m_data_byteen;
  logic [31:0] m_data_wdata;
  logic [2:0]  dm_op;
  logic [31:0] m_data_rdata;
  logic        busy;
  logic        addr_err;
  logic [31:0] wr_count;

  int total = 0;
  int bad   = 0;

  dm_responder #(.DEPTH(16), .ADDR_W(4)) dut (
    .clk(clk),
    .reset(reset),
    .m_data_addr(m_data_addr),
    .m_data_byteen(m_data_byteen),
    .m_data_wdata(m_data_wdata),
    .dm_op(dm_op),
    .m_data_rdata(m_data_rdata),
    .busy(busy),
    .addr_err(addr_err),
    .wr_count(wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change just after the falling edge; outputs are sampled 1 ns later.
  task automatic drive(input logic [31:0] a, input logic [3:0] be,
                       input logic [31:0] wd, input logic [2:0] op);
    m_data_addr   = a;
    m_data_byteen = be;
    m_data_wdata  = wd;
    dm_op         = op;
    #1;
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Counts falling edges with busy high, starting at the edge where reset dropped.
  task automatic measure_busy(output int cnt);
    cnt = 0;
    #1;
    while (busy === 1'b1 && cnt < 40) begin
      cnt++;
      @(negedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    int cnt;
    drive(32'h0, 4'b0000, 32'h0, 3'd0);
    pulse_reset();
    #1;
    total++;
    if (m_data_rdata !== 32'h0) begin
      bad++;
      $display("[TB] FAIL init_rdata actual=%h required=%h", m_data_rdata, 32'h0);
    end
    measure_busy(cnt);
    total++;
    if (cnt != 16) begin
      bad++;
      $display("[TB] FAIL busy_len actual=%0d required=%0d", cnt, 16);
    end
    for (int a = 0; a < 64; a += 4) begin
      drive(32'(a), 4'b0000, 32'h0, 3'd0);
      total++;
      if (m_data_rdata !== 32'h0) begin
        bad++;
        $display("[TB] FAIL cleared_word addr=%h actual=%h required=%h", a, m_data_rdata, 32'h0);
      end
    end
    total++;
    if (wr_count !== 32'd0 || addr_err !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_regs actual=%h/%b required=0/0", wr_count, addr_err);
    end
  endtask

  task automatic test_store_word();
    next_cycle();
    drive(32'h8, 4'b1111, 32'h8765_4321, 3'd0);
    next_cycle();
    drive(32'h8, 4'b0000, 32'h0, 3'd0);
    total++;
    if (m_data_rdata !== 32'h8765_4321) begin
      bad++;
      $display("[TB] FAIL sw_read actual=%h required=%h", m_data_rdata, 32'h8765_4321);
    end
    total++;
    if (wr_count !== 32'd1) begin
      bad++;
      $display("[TB] FAIL sw_count actual=%0d required=%0d", wr_count, 1);
    end
  endtask

  task automatic test_store_byte();
    next_cycle();
    drive(32'hA, 4'b0100, 32'h00AB_0000, 3'd0);
    next_cycle();
    drive(32'hA, 4'b0000, 32'h0, 3'd0);
    total++;
    if (m_data_rdata !== 32'h87AB_4321) begin
      bad++;
      $display("[TB] FAIL sb_word actual=%h required=%h", m_data_rdata, 32'h87AB_4321);
    end
    drive(32'hA, 4'b0000, 32'h0, 3'd2);
    total++;
    if (m_data_rdata !== 32'hFFFF_FFAB) begin
      bad++;
      $display("[TB] FAIL lb_sign actual=%h required=%h", m_data_rdata, 32'hFFFF_FFAB);
    end
    drive(32'hA, 4'b0000, 32'h0, 3'd1);
    total++;
    if (m_data_rdata !== 32'h0000_00AB) begin
      bad++;
      $display("[TB] FAIL lbu actual=%h required=%h", m_data_rdata, 32'h0000_00AB);
    end
    drive(32'h9, 4'b0000, 32'h0, 3'd2);
    total++;
    if (m_data_rdata !== 32'h0000_0043) begin
      bad++;
      $display("[TB] FAIL lb_lane1 actual=%h required=%h", m_data_rdata, 32'h0000_0043);
    end
    drive(32'hB, 4'b0000, 32'h0, 3'd2);
    total++;
    if (m_data_rdata !== 32'hFFFF_FF87) begin
      bad++;
      $display("[TB] FAIL lb_lane3 actual=%h required=%h", m_data_rdata, 32'hFFFF_FF87);
    end
    total++;
    if (wr_count !== 32'd2) begin
      bad++;
      $display("[TB] FAIL sb_count actual=%0d required=%0d", wr_count, 2);
    end
  endtask

  task automatic test_halves_and_bypass();
    drive(32'hA, 4'b0000, 32'h0, 3'd4);
    total++;
    if (m_data_rdata !== 32'hFFFF_87AB) begin
      bad++;
      $display("[TB] FAIL lh_hi actual=%h required=%h", m_data_rdata, 32'hFFFF_87AB);
    end
    drive(32'hA, 4'b0000, 32'h0, 3'd3);
    total++;
    if (m_data_rdata !== 32'h0000_87AB) begin
      bad++;
      $display("[TB] FAIL lhu_hi actual=%h required=%h", m_data_rdata, 32'h0000_87AB);
    end
    drive(32'hB, 4'b0000, 32'h0, 3'd4);
    total++;
    if (m_data_rdata !== 32'hFFFF_87AB) begin
      bad++;
      $display("[TB] FAIL lh_odd actual=%h required=%h", m_data_rdata, 32'hFFFF_87AB);
    end
    drive(32'h8, 4'b0000, 32'h0, 3'd4);
    total++;
    if (m_data_rdata !== 32'h0000_4321) begin
      bad++;
      $display("[TB] FAIL lh_lo actual=%h required=%h", m_data_rdata, 32'h0000_4321);
    end
    drive(32'h8, 4'b0000, 32'h0, 3'd5);
    total++;
    if (m_data_rdata !== 32'h87AB_4321) begin
      bad++;
      $display("[TB] FAIL op5_word actual=%h required=%h", m_data_rdata, 32'h87AB_4321);
    end
    next_cycle();
    drive(32'h8, 4'b1111, 32'h1122_3344, 3'd0);
    total++;
    if (m_data_rdata !== 32'h87AB_4321) begin
      bad++;
      $display("[TB] FAIL same_cycle_old actual=%h required=%h", m_data_rdata, 32'h87AB_4321);
    end
    next_cycle();
    drive(32'h8, 4'b0000, 32'h0, 3'd0);
    total++;
    if (m_data_rdata !== 32'h1122_3344) begin
      bad++;
      $display("[TB] FAIL same_cycle_new actual=%h required=%h", m_data_rdata, 32'h1122_3344);
    end
    total++;
    if (wr_count !== 32'd3) begin
      bad++;
      $display("[TB] FAIL bypass_count actual=%0d required=%0d", wr_count, 3);
    end
  endtask

  task automatic test_out_of_range();
    next_cycle();
    drive(32'h40, 4'b1111, 32'hDEAD_BEEF, 3'd0);
    total++;
    if (addr_err !== 1'b0) begin
      bad++;
      $display("[TB] FAIL err_early actual=%b required=%b", addr_err, 1'b0);
    end
    next_cycle();
    drive(32'h40, 4'b0000, 32'h0, 3'd0);
    total++;
    if (addr_err !== 1'b1) begin
      bad++;
      $display("[TB] FAIL err_set actual=%b required=%b", addr_err, 1'b1);
    end
    total++;
    if (m_data_rdata !== 32'h0) begin
      bad++;
      $display("[TB] FAIL oor_read actual=%h required=%h", m_data_rdata, 32'h0);
    end
    total++;
    if (wr_count !== 32'd3) begin
      bad++;
      $display("[TB] FAIL oor_count actual=%0d required=%0d", wr_count, 3);
    end
    drive(32'h0, 4'b0000, 32'h0, 3'd0);
    total++;
    if (m_data_rdata !== 32'h0) begin
      bad++;
      $display("[TB] FAIL oor_alias actual=%h required=%h", m_data_rdata, 32'h0);
    end
    drive(32'h1000_0008, 4'b0000, 32'h0, 3'd0);
    total++;
    if (m_data_rdata !== 32'h0) begin
      bad++;
      $display("[TB] FAIL oor_high_read actual=%h required=%h", m_data_rdata, 32'h0);
    end
    next_cycle();
    next_cycle();
    next_cycle();
    #1;
    total++;
    if (addr_err !== 1'b1) begin
      bad++;
      $display("[TB] FAIL err_sticky actual=%b required=%b", addr_err, 1'b1);
    end
  endtask

  task automatic test_reset_recovery();
    int cnt;
    next_cycle();
    drive(32'h8, 4'b1111, 32'hFFFF_FFFF, 3'd0);
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    #1;
    total++;
    if (wr_count !== 32'd0 || addr_err !== 1'b0) begin
      bad++;
      $display("[TB] FAIL rst_regs actual=%h/%b required=0/0", wr_count, addr_err);
    end
    // Stores are held on the bus through the whole sweep and must be ignored.
    measure_busy(cnt);
    total++;
    if (cnt != 16) begin
      bad++;
      $display("[TB] FAIL rst_busy_len actual=%0d required=%0d", cnt, 16);
    end
    drive(32'h8, 4'b0000, 32'h0, 3'd0);
    total++;
    if (m_data_rdata !== 32'h0) begin
      bad++;
      $display("[TB] FAIL rst_word8 actual=%h required=%h", m_data_rdata, 32'h0);
    end
    total++;
    if (wr_count !== 32'd0 || addr_err !== 1'b0) begin
      bad++;
      $display("[TB] FAIL busy_store_ignored actual=%h/%b required=0/0", wr_count, addr_err);
    end
    next_cycle();
    drive(32'h44, 4'b1111, 32'h0, 3'd0);
    next_cycle();
    drive(32'hC, 4'b0011, 32'h0000_5555, 3'd0);
    next_cycle();
    drive(32'hC, 4'b0000, 32'h0, 3'd0);
    total++;
    if (m_data_rdata !== 32'h0000_5555 || addr_err !== 1'b1 || wr_count !== 32'd1) begin
      bad++;
      $display("[TB] FAIL pre_reset_state actual=%h/%b/%0d required=00005555/1/1",
               m_data_rdata, addr_err, wr_count);
    end
    pulse_reset();
    for (int k = 0; k < 7; k++) next_cycle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    measure_busy(cnt);
    total++;
    if (cnt != 16) begin
      bad++;
      $display("[TB] FAIL mid_sweep_busy_len actual=%0d required=%0d", cnt, 16);
    end
    drive(32'hC, 4'b0000, 32'h0, 3'd0);
    total++;
    if (m_data_rdata !== 32'h0 || addr_err !== 1'b0 || wr_count !== 32'd0) begin
      bad++;
      $display("[TB] FAIL mid_sweep_state actual=%h/%b/%0d required=0/0/0",
               m_data_rdata, addr_err, wr_count);
    end
  endtask

  initial begin
    reset         = 1'b0;
    m_data_addr   = 32'h0;
    m_data_byteen = 4'b0000;
    m_data_wdata  = 32'h0;
    dm_op         = 3'd0;
    test_reset();
    test_store_word();
    test_store_byte();
    test_halves_and_bypass();
    test_out_of_range();
    test_reset_recovery();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
